// File: rtl/byte_arbiter2_if.sv
// rtl/byte_arbiter2_if.sv - two-requester / one-memory bus bundle for byte_arbiter2
interface byte_arbiter2_if #(
    parameter int DATA_BYTE = 4,
    parameter int ADDR_SIZE = 32
);
    logic                   aEnable_i;
    logic                   aIsWrite_i;
    logic [DATA_BYTE-1:0]   aWriteMask_i;
    logic [ADDR_SIZE-1:0]   aAddr_i;
    logic [DATA_BYTE*8-1:0] aWriteData_i;
    logic [DATA_BYTE*8-1:0] aReadData_o;
    logic                   aHold_o;

    logic                   bEnable_i;
    logic                   bIsWrite_i;
    logic [DATA_BYTE-1:0]   bWriteMask_i;
    logic [ADDR_SIZE-1:0]   bAddr_i;
    logic [DATA_BYTE*8-1:0] bWriteData_i;
    logic [DATA_BYTE*8-1:0] bReadData_o;
    logic                   bHold_o;

    logic                   memEnable_o;
    logic                   memIsWrite_o;
    logic [DATA_BYTE-1:0]   memWriteMask_o;
    logic [ADDR_SIZE-1:0]   memAddr_o;
    logic [DATA_BYTE*8-1:0] memWriteData_o;
    logic [DATA_BYTE*8-1:0] memReadData_i;
    logic                   memHold_i;

    modport slave (
        input  aEnable_i, aIsWrite_i, aWriteMask_i, aAddr_i, aWriteData_i,
        output aReadData_o, aHold_o,
        input  bEnable_i, bIsWrite_i, bWriteMask_i, bAddr_i, bWriteData_i,
        output bReadData_o, bHold_o,
        output memEnable_o, memIsWrite_o, memWriteMask_o, memAddr_o, memWriteData_o,
        input  memReadData_i, memHold_i
    );

    modport master (
        output aEnable_i, aIsWrite_i, aWriteMask_i, aAddr_i, aWriteData_i,
        input  aReadData_o, aHold_o,
        output bEnable_i, bIsWrite_i, bWriteMask_i, bAddr_i, bWriteData_i,
        input  bReadData_o, bHold_o,
        input  memEnable_o, memIsWrite_o, memWriteMask_o, memAddr_o, memWriteData_o,
        output memReadData_i, memHold_i
    );
endinterface

// File: rtl/byte_arbiter2.sv
// rtl/byte_arbiter2.sv - zero-latency round-robin arbiter of two requesters onto one memory port
module byte_arbiter2 #(
    parameter int DATA_BYTE = 4,
    parameter int ADDR_SIZE = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    byte_arbiter2_if.slave   bus
);
    typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_t;

    port_t last_grant, lock_port, rd_owner, grant_port;
    logic  lock_valid, grant_valid, accept;

    logic                   sel_wr;
    logic [DATA_BYTE-1:0]   sel_mask;
    logic [ADDR_SIZE-1:0]   sel_addr;
    logic [DATA_BYTE*8-1:0] sel_wdata;
    logic                   lock_en;

    // A stalled grant stays pinned to its port until accepted or withdrawn.
    always_comb begin
        grant_valid = 1'b0;
        grant_port  = PORT_A;
        lock_en     = (lock_port == PORT_A) ? bus.aEnable_i : bus.bEnable_i;
        if (lock_valid && lock_en) begin
            grant_valid = 1'b1;
            grant_port  = lock_port;
        end else if (bus.aEnable_i && bus.bEnable_i) begin
            grant_valid = 1'b1;
            grant_port  = (last_grant == PORT_A) ? PORT_B : PORT_A;
        end else if (bus.aEnable_i) begin
            grant_valid = 1'b1;
            grant_port  = PORT_A;
        end else if (bus.bEnable_i) begin
            grant_valid = 1'b1;
            grant_port  = PORT_B;
        end
    end

    always_comb begin
        sel_wr    = (grant_port == PORT_A) ? bus.aIsWrite_i   : bus.bIsWrite_i;
        sel_mask  = (grant_port == PORT_A) ? bus.aWriteMask_i : bus.bWriteMask_i;
        sel_addr  = (grant_port == PORT_A) ? bus.aAddr_i      : bus.bAddr_i;
        sel_wdata = (grant_port == PORT_A) ? bus.aWriteData_i : bus.bWriteData_i;
        accept    = grant_valid && !bus.memHold_i;
    end

    always_comb begin
        bus.memEnable_o    = grant_valid;
        bus.memIsWrite_o   = grant_valid ? sel_wr    : 1'b0;
        bus.memWriteMask_o = grant_valid ? sel_mask  : '0;
        bus.memAddr_o      = grant_valid ? sel_addr  : '0;
        bus.memWriteData_o = grant_valid ? sel_wdata : '0;

        bus.aHold_o = bus.aEnable_i;
        bus.bHold_o = bus.bEnable_i;
        if (grant_valid && grant_port == PORT_A) bus.aHold_o = bus.memHold_i;
        if (grant_valid && grant_port == PORT_B) bus.bHold_o = bus.memHold_i;

        bus.aReadData_o = (rd_owner == PORT_A) ? bus.memReadData_i : '0;
        bus.bReadData_o = (rd_owner == PORT_B) ? bus.memReadData_i : '0;
    end

    // Lock is exactly "granted but stalled last cycle": acceptance, withdrawal
    // and idle cycles all fall out as lock_valid=0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_valid <= 1'b0;
            lock_port  <= PORT_A;
            last_grant <= PORT_B;
            rd_owner   <= PORT_A;
        end else begin
            lock_valid <= grant_valid && bus.memHold_i;
            if (grant_valid && bus.memHold_i) lock_port <= grant_port;
            if (accept) begin
                last_grant <= grant_port;
                if (!sel_wr) rd_owner <= grant_port;
            end
        end
    end
endmodule

// File: tb/tb_byte_arbiter2.sv
// tb/tb_byte_arbiter2.sv - directed plus randomized check of byte_arbiter2 against a rule-level model
module tb_byte_arbiter2;
    logic clk;
    logic rst;

    byte_arbiter2_if #(.DATA_BYTE(4), .ADDR_SIZE(32)) bus ();

    byte_arbiter2 #(.DATA_BYTE(4), .ADDR_SIZE(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bit          en   [2];
    bit          wr   [2];
    logic [3:0]  mask [2];
    logic [31:0] addr [2];
    logic [31:0] wd   [2];
    bit          mh;
    logic [31:0] md;

    int m_last, m_lock_v, m_lock_p, m_rd;
    bit known;
    bit prev_rst;
    bit exp_hold [2];

    int vectors;
    int miscompares;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_grant();
        if (m_lock_v != 0 && en[m_lock_p]) return m_lock_p;
        if (en[0] && en[1]) return 1 - m_last;
        if (en[0]) return 0;
        if (en[1]) return 1;
        return -1;
    endfunction

    task automatic drive();
        rst                = prev_rst;
        bus.aEnable_i      = en[0];
        bus.aIsWrite_i     = wr[0];
        bus.aWriteMask_i   = mask[0];
        bus.aAddr_i        = addr[0];
        bus.aWriteData_i   = wd[0];
        bus.bEnable_i      = en[1];
        bus.bIsWrite_i     = wr[1];
        bus.bWriteMask_i   = mask[1];
        bus.bAddr_i        = addr[1];
        bus.bWriteData_i   = wd[1];
        bus.memHold_i      = mh;
        bus.memReadData_i  = md;
    endtask

    task automatic check_all();
        int g;
        g = model_grant();
        for (int p = 0; p < 2; p++)
            exp_hold[p] = (g == p) ? mh : en[p];
        check_eq("mem_enable", bus.memEnable_o, (g >= 0));
        check_eq("mem_is_write", bus.memIsWrite_o, (g >= 0) ? wr[g] : 1'b0);
        check_eq("mem_mask", bus.memWriteMask_o, (g >= 0) ? mask[g] : 4'h0);
        check_eq("mem_addr", bus.memAddr_o, (g >= 0) ? addr[g] : 32'h0);
        check_eq("mem_wdata", bus.memWriteData_o, (g >= 0) ? wd[g] : 32'h0);
        check_eq("a_hold", bus.aHold_o, exp_hold[0]);
        check_eq("b_hold", bus.bHold_o, exp_hold[1]);
        check_eq("a_rdata", bus.aReadData_o, (m_rd == 0) ? md : 32'h0);
        check_eq("b_rdata", bus.bReadData_o, (m_rd == 1) ? md : 32'h0);
    endtask

    task automatic update_model();
        int g;
        bit accepted;
        g = model_grant();
        accepted = (g >= 0) && !mh;
        if (prev_rst) begin
            m_lock_v = 0; m_lock_p = 0; m_last = 1; m_rd = 0;
            known = 1'b1;
        end else begin
            if (g >= 0 && mh) begin
                m_lock_v = 1; m_lock_p = g;
            end else if (accepted) begin
                m_lock_v = 0;
            end else if (m_lock_v != 0 && !en[m_lock_p]) begin
                m_lock_v = 0;
            end
            if (accepted) begin
                m_last = g;
                if (!wr[g]) m_rd = g;
            end
        end
    endtask

    task automatic run_cycle();
        @(negedge clk);
        drive();
        #1;
        if (known) check_all();
        @(posedge clk);
        update_model();
    endtask

    task automatic set_req(input int p, input bit e, input bit w, input logic [3:0] m,
                           input logic [31:0] a, input logic [31:0] d);
        en[p] = e; wr[p] = w; mask[p] = m; addr[p] = a; wd[p] = d;
    endtask

    task automatic step(input bit r, input bit hold, input logic [31:0] rdata);
        prev_rst = r; mh = hold; md = rdata;
        run_cycle();
    endtask

    task automatic idle_both();
        set_req(0, 0, 0, 4'h0, 32'h0, 32'h0);
        set_req(1, 0, 0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        vectors = 0; miscompares = 0; known = 1'b0;
        m_last = 1; m_lock_v = 0; m_lock_p = 0; m_rd = 0;
        idle_both(); mh = 1'b0; md = '0; prev_rst = 1'b1;

        step(1, 0, 32'h0);
        step(1, 0, 32'h1111_2222);

        set_req(0, 1, 0, 4'h0, 32'h100, 32'h0);
        step(0, 0, 32'h0);
        idle_both();
        step(0, 0, 32'hDEAD_BEEF);

        step(1, 0, 32'h0);
        set_req(0, 1, 1, 4'hF, 32'h200, 32'hA0A0_A0A0);
        set_req(1, 1, 1, 4'hF, 32'h300, 32'hB0B0_B0B0);
        for (int i = 0; i < 4; i++) step(0, 0, 32'h0);

        idle_both();
        set_req(1, 1, 0, 4'h0, 32'h400, 32'h0);
        step(0, 1, 32'h0);
        set_req(0, 1, 0, 4'h0, 32'h500, 32'h0);
        for (int i = 0; i < 3; i++) step(0, 1, 32'h0);
        step(0, 0, 32'h0);
        set_req(1, 0, 0, 4'h0, 32'h0, 32'h0);
        step(0, 0, 32'h1234_5678);
        idle_both();

        set_req(1, 1, 1, 4'h3, 32'h600, 32'h5555_AAAA);
        step(0, 0, 32'h0);
        idle_both();
        set_req(0, 1, 0, 4'h0, 32'h700, 32'h0);
        step(0, 0, 32'h0);
        idle_both();
        step(0, 0, 32'hCAFE_F00D);

        set_req(0, 1, 0, 4'h0, 32'h800, 32'h0);
        step(0, 1, 32'h0);
        set_req(0, 0, 0, 4'h0, 32'h0, 32'h0);
        set_req(1, 1, 0, 4'h0, 32'h900, 32'h0);
        step(0, 1, 32'h0);
        step(0, 0, 32'h0);
        idle_both();

        set_req(1, 1, 0, 4'h0, 32'hA00, 32'h0);
        step(0, 1, 32'h0);
        set_req(0, 1, 0, 4'h0, 32'hB00, 32'h0);
        step(0, 1, 32'h0);
        step(1, 1, 32'h0);
        step(0, 0, 32'h0);
        step(0, 0, 32'h0);
        idle_both();

        for (int c = 0; c < 2000; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (prev_rst || !(en[p] && exp_hold[p])) begin
                    set_req(p, ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                            4'($urandom), $urandom, $urandom);
                end
            end
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/byte_arbiter2.md
BYTE_ARBITER2 -- requirements
Module: byte_arbiter2

Interface
REQ-001 SHALL have parameter DATA_BYTE, default 4, meaning data width in bytes.
REQ-002 SHALL have parameter ADDR_SIZE, default 32, meaning address width in bits.
REQ-003 SHALL have port clk_i  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, synchronous and active-high.
REQ-005 SHALL have, for each requester port p in {a,b}, the following inputs: pEnable_i (1), pIsWrite_i (1), pWriteMask_i (DATA_BYTE), pAddr_i (ADDR_SIZE), pWriteData_i (DATA_BYTE*8).
REQ-006 SHALL have, for each requester port p in {a,b}, the following outputs: pReadData_o (DATA_BYTE*8) and pHold_o (1), where hold=1 means the request is not accepted this cycle.
REQ-007 SHALL have outputs memEnable_o (1), memIsWrite_o (1), memWriteMask_o (DATA_BYTE), memAddr_o (ADDR_SIZE) and memWriteData_o (DATA_BYTE*8), all forwarded from the granted port.
REQ-008 SHALL have inputs memReadData_i (DATA_BYTE*8) and memHold_i (1) from the memory port.

Function
REQ-009 SHALL treat a request as accepted in a cycle where its enable is 1 and its hold output is 0; a requester whose hold is 1 keeps its request stable.
REQ-010 SHALL use the following read timing: read data for an accepted read is valid on memReadData_i in the cycle after acceptance.
REQ-011 SHALL keep state: lastGrant (0=a, 1=b), lockValid, lockPort, rdOwner.
REQ-012 SHALL select the grant combinationally, in this order:
- If lockValid and the locked port's enable is 1, grant the locked port.
- Otherwise, if exactly one port is enabled, grant that port.
- Otherwise, if both are enabled, grant the port that is not lastGrant (round-robin).
- Otherwise there is no grant.
REQ-013 SHALL, with a grant, drive all mem*_o outputs from the granted port's inputs, with memEnable_o=1.
REQ-014 SHALL, with no grant, drive memEnable_o=0 and all other mem*_o outputs to 0.
REQ-015 SHALL drive the granted port's hold output as memHold_i; SHALL drive 1 on the other port's hold output if that port is enabled; SHALL drive 0 on an idle port's hold output.
REQ-016 SHALL set lockValid=1 and lockPort=granted port in the next cycle when a grant occurs with memHold_i=1.
REQ-017 SHALL clear lockValid on acceptance, or when the locked port's enable is 0.
REQ-018 SHALL set lastGrant to the granted port on each acceptance; lastGrant is unchanged otherwise.
REQ-019 SHALL set rdOwner to the granted port on acceptance of a read (isWrite=0); rdOwner is unchanged for writes.
REQ-020 SHALL drive the rdOwner port's ReadData output combinationally from memReadData_i, and the other port's ReadData output to 0.
REQ-021 SHALL add zero cycles of latency to requests and read data; it has no buffering.
REQ-022 SHALL pass back-to-back acceptances at one per cycle, alternating a/b when both ports request continuously and memHold_i=0.
REQ-023 SHALL NOT switch the grant while lockValid=1 and the locked port is still enabled, even if the other port's priority is higher.

Reset
REQ-024 SHALL, when rst_i=1 at a clock edge, set lockValid=0, lockPort=0, lastGrant=1 (so a wins the first tie) and rdOwner=0.
REQ-025 SHALL, during reset, have outputs that follow REQ-012 to REQ-020 from the reset state values; a transaction in flight at reset is dropped.

Verification
REQ-026 SHALL be verified by: a alone reads 0x100 with memHold_i=0 -> memAddr_o=0x100, aHold_o=0; next cycle aReadData_o=memReadData_i and bReadData_o=0.
REQ-027 SHALL be verified by: after reset, a and b both enabled for 4 cycles with memHold_i=0 -> grants in order a, b, a, b; the non-granted port's hold=1 each cycle.
REQ-028 SHALL be verified by: b granted with memHold_i=1 for 3 cycles while a also requests -> grant stays b, aHold_o=1; memHold_i drops -> b accepted, a granted next cycle.
REQ-029 SHALL be verified by: b write (mask 0x3) accepted, then a read accepted -> rdOwner=a; next cycle aReadData_o carries the data and bReadData_o=0.
REQ-030 SHALL be verified by: lock held on a, then aEnable_i drops while b is enabled -> same cycle grant=b, lockValid cleared.
REQ-031 SHALL be verified by: rst_i=1 asserted while locked on b -> next cycle lockValid=0 and lastGrant=1; a wins the next tie.
